// File: rtl/h264dc_hadamard_if.sv
`default_nettype none
// ============================================================================
// Module   : h264dc_hadamard_if
// Brief    : Sample-in / coefficient-out handshake bundle for the DC Hadamard
//            transform. "master" is the surrounding pipeline (drives samples
//            and READYO), "slave" is the transform block.
// Revision : 1.0  initial release
// ============================================================================
interface h264dc_hadamard_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 20
);
  logic                        READYI;
  logic                        ENABLE;
  logic                        MODE;
  logic signed [IN_WIDTH-1:0]  XXIN;
  logic                        VALID;
  logic signed [OUT_WIDTH-1:0] YYOUT;
  logic [3:0]                  YYIDX;
  logic                        LAST;
  logic                        READYO;

  modport master (
    output ENABLE, MODE, XXIN, READYO,
    input  READYI, VALID, YYOUT, YYIDX, LAST
  );

  modport slave (
    input  ENABLE, MODE, XXIN, READYO,
    output READYI, VALID, YYOUT, YYIDX, LAST
  );
endinterface
`default_nettype wire

// File: rtl/h264dc_hadamard.sv
`default_nettype none
// ============================================================================
// Module   : h264dc_hadamard
// Brief    : DC-coefficient Hadamard transform for 2x2 chroma DC (MODE=0) and
//            4x4 Intra16x16 luma DC (MODE=1) blocks. Collects a block
//            serially, runs a row pass then a column pass (one cycle each),
//            and emits unscaled full-precision results in raster order.
// Revision : 1.0  initial release
// ============================================================================
module h264dc_hadamard #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 20,
  parameter int TOGETHER  = 0
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  h264dc_hadamard_if.slave bus
);

  // Negative-sign positions of H4, bit index = row*4 + col.
  // Rows: [+ + + +] [+ + - -] [+ - - +] [+ - + -]
  localparam logic [15:0] c_H4_NEG = 16'hA6C0;
  // Negative-sign positions of H2, bit index = row*2 + col: only (1,1).
  localparam logic [3:0]  c_H2_NEG = 4'b1000;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ROW  = 2'd1,
    S_COL  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic signed [IN_WIDTH-1:0]  r_buf [16];
  logic signed [OUT_WIDTH-1:0] r_row [16];
  logic signed [OUT_WIDTH-1:0] r_col [16];
  logic signed [OUT_WIDTH-1:0] w_row [16];
  logic signed [OUT_WIDTH-1:0] w_col [16];

  logic                        r_mode;
  logic [3:0]                  r_cnt;
  logic                        r_valid;
  logic signed [OUT_WIDTH-1:0] r_yyout;
  logic [3:0]                  r_yyidx;
  logic                        r_last;

  logic                        w_ready;
  logic                        w_accept;
  logic                        w_emit;
  logic                        w_cnt_end;
  logic [3:0]                  w_last_idx;

  // Ready is held low during reset so nothing is accepted while aborting.
  assign w_ready    = (r_state == S_LOAD) && !RESET;
  assign w_accept   = w_ready && bus.ENABLE;
  // Once coefficient 0 has gone out, a grouped block ignores backpressure.
  assign w_emit     = bus.READYO || ((TOGETHER != 0) && (r_cnt != 4'd0));
  // r_mode is already latched whenever r_cnt can reach the final index.
  assign w_last_idx = r_mode ? 4'd15 : 4'd3;
  assign w_cnt_end  = (r_cnt == w_last_idx);

  assign bus.READYI = w_ready;
  assign bus.VALID  = r_valid;
  assign bus.YYOUT  = r_yyout;
  assign bus.YYIDX  = r_yyidx;
  assign bus.LAST   = r_last;

  // Row pass: T[r][j] = sum_c X[r][c] * H[j][c], sign-extended to OUT_WIDTH.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_row[k] = '0;
    end
    if (r_mode) begin
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < 4; j++) begin
          for (int c = 0; c < 4; c++) begin
            if (c_H4_NEG[j*4+c]) begin
              w_row[r*4+j] = w_row[r*4+j] - OUT_WIDTH'(r_buf[r*4+c]);
            end else begin
              w_row[r*4+j] = w_row[r*4+j] + OUT_WIDTH'(r_buf[r*4+c]);
            end
          end
        end
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        for (int j = 0; j < 2; j++) begin
          for (int c = 0; c < 2; c++) begin
            if (c_H2_NEG[j*2+c]) begin
              w_row[r*2+j] = w_row[r*2+j] - OUT_WIDTH'(r_buf[r*2+c]);
            end else begin
              w_row[r*2+j] = w_row[r*2+j] + OUT_WIDTH'(r_buf[r*2+c]);
            end
          end
        end
      end
    end
  end

  // Column pass: Y[i][j] = sum_r H[i][r] * T[r][j].
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_col[k] = '0;
    end
    if (r_mode) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          for (int r = 0; r < 4; r++) begin
            if (c_H4_NEG[i*4+r]) begin
              w_col[i*4+j] = w_col[i*4+j] - r_row[r*4+j];
            end else begin
              w_col[i*4+j] = w_col[i*4+j] + r_row[r*4+j];
            end
          end
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          for (int r = 0; r < 2; r++) begin
            if (c_H2_NEG[i*2+r]) begin
              w_col[i*2+j] = w_col[i*2+j] - r_row[r*2+j];
            end else begin
              w_col[i*2+j] = w_col[i*2+j] + r_row[r*2+j];
            end
          end
        end
      end
    end
  end

  // Next-state decode for the load / row / column / output sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_accept && w_cnt_end) w_state_nxt = S_ROW;
      S_ROW:   w_state_nxt = S_COL;
      S_COL:   w_state_nxt = S_OUT;
      S_OUT:   if (w_emit && w_cnt_end) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // State register; reset aborts any block in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample buffer and pass banks; stale contents are harmless since the
  // counter restarts at zero and every entry is rewritten before use.
  always_ff @(posedge CLK) begin
    if (r_state == S_LOAD && w_accept) begin
      r_buf[r_cnt] <= bus.XXIN;
    end
    if (r_state == S_ROW) begin
      r_row <= w_row;
    end
    if (r_state == S_COL) begin
      r_col <= w_col;
    end
  end

  // Sample/coefficient counter, mode latch and registered output stage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mode  <= 1'b0;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_yyout <= '0;
      r_yyidx <= 4'd0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (r_cnt == 4'd0) begin
              r_mode <= bus.MODE;
            end
            r_cnt <= w_cnt_end ? 4'd0 : r_cnt + 4'd1;
          end
        end
        S_OUT: begin
          if (w_emit) begin
            r_valid <= 1'b1;
            r_yyout <= r_col[r_cnt];
            r_yyidx <= r_cnt;
            r_last  <= w_cnt_end;
            r_cnt   <= w_cnt_end ? 4'd0 : r_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_h264dc_hadamard.sv
`default_nettype none
// ============================================================================
// Module   : tb_h264dc_hadamard
// Brief    : Directed bench for h264dc_hadamard. Two instances (TOGETHER=0
//            and TOGETHER=1) share one stimulus stream; outputs are captured
//            into queues and compared with hand-computed transforms.
// Revision : 1.0  initial release
// ============================================================================
module tb_h264dc_hadamard;

  localparam int IW = 16;
  localparam int OW = 20;

  typedef struct {
    int val;
    int idx;
    int last;
    int cyc;
  } rec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 md;
  logic                 ro;
  logic signed [IW-1:0] xin;
  int                   cyc = 0;
  int                   checks = 0;
  int                   errors = 0;
  rec_t                 q0[$];
  rec_t                 q1[$];

  h264dc_hadamard_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus0 ();
  h264dc_hadamard_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus1 ();

  assign bus0.ENABLE = en;
  assign bus0.MODE   = md;
  assign bus0.XXIN   = xin;
  assign bus0.READYO = ro;
  assign bus1.ENABLE = en;
  assign bus1.MODE   = md;
  assign bus1.XXIN   = xin;
  assign bus1.READYO = ro;

  h264dc_hadamard #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TOGETHER(0)) u_dut0 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus0.slave)
  );

  h264dc_hadamard #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TOGETHER(1)) u_dut1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every emitted coefficient with the cycle it became visible.
  always @(negedge clk) begin
    if (bus0.VALID === 1'b1) q0.push_back('{int'(bus0.YYOUT), int'(bus0.YYIDX), int'(bus0.LAST), cyc});
    if (bus1.VALID === 1'b1) q1.push_back('{int'(bus1.YYOUT), int'(bus1.YYIDX), int'(bus1.LAST), cyc});
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q;
    q0.delete();
    q1.delete();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en  = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    clear_q();
  endtask

  // Feed one block; while the DUTs are busy, garbage is driven with ENABLE=1
  // and the opposite MODE so that dropped samples would corrupt the result.
  task automatic send_block(input bit mode, input int n, input int vals[16], input bit wrong,
                            output int f_cyc, output int e_cyc);
    f_cyc = -1;
    e_cyc = -1;
    for (int i = 0; i < n; i++) begin
      int g = 0;
      while (!(bus0.READYI === 1'b1 && bus1.READYI === 1'b1) && g < 400) begin
        en  = 1'b1;
        xin = 16'sd999;
        md  = ~mode;
        tick;
        g++;
      end
      if (g >= 400) begin
        check("ready_timeout", 0, 1);
        en = 1'b0;
        return;
      end
      en  = 1'b1;
      xin = vals[i][IW-1:0];
      md  = (i == 0) ? mode : (wrong ? ~mode : mode);
      tick;
      if (i == 0) f_cyc = cyc;
    end
    en    = 1'b0;
    e_cyc = cyc;
  endtask

  task automatic wait_outs(input int n);
    int g = 0;
    while ((q0.size() < n || q1.size() < n) && g < 400) begin
      tick;
      g++;
    end
    if (g >= 400) check("out_timeout", q0.size(), n);
  endtask

  task automatic check_outs(input string tag, input rec_t q[$], input int off,
                            input int exp[16], input int n);
    for (int i = 0; i < n; i++) begin
      if (off + i < q.size()) begin
        check($sformatf("%s_y%0d", tag, i), q[off+i].val, exp[i]);
        check($sformatf("%s_idx%0d", tag, i), q[off+i].idx, i);
        check($sformatf("%s_last%0d", tag, i), q[off+i].last, (i == n-1) ? 1 : 0);
      end else begin
        check($sformatf("%s_missing%0d", tag, i), q.size(), off + i + 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int vin[16];
    int ex[16];
    int v22[16];
    int e22[16];
    int v44[16];
    int e44[16];
    int f1, e1, f2, e2;
    int bp_pat[7];
    int exp0_cyc[4];
    int exp1_cyc[4];

    rst = 1'b1;
    en  = 1'b0;
    md  = 1'b0;
    xin = '0;
    ro  = 1'b1;
    tick;
    tick;
    check("rst_readyi", bus0.READYI, 0);
    check("rst_valid", bus0.VALID, 0);
    check("rst_yyout", bus0.YYOUT, 0);
    check("rst_yyidx", bus0.YYIDX, 0);
    check("rst_last", bus0.LAST, 0);
    rst = 1'b0;
    #1;
    check("readyi_after_rst", bus0.READYI, 1);
    tick;

    // 2x2 basic: [[1,2],[3,4]] -> [[10,-2],[-4,0]]
    clear_q();
    v22 = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    e22 = '{10, -2, -4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_block(1'b0, 4, v22, 1'b0, f1, e1);
    wait_outs(4);
    check("t22_count", q0.size(), 4);
    check_outs("t22", q0, 0, e22, 4);
    check_outs("t22g", q1, 0, e22, 4);
    if (q0.size() > 0) check("t22_latency", q0[0].cyc - e1, 3);
    tick;

    // 4x4 all ones -> 16 then zeros
    clear_q();
    for (int i = 0; i < 16; i++) begin
      vin[i] = 1;
      ex[i]  = (i == 0) ? 16 : 0;
    end
    send_block(1'b1, 16, vin, 1'b0, f1, e1);
    wait_outs(16);
    check("ones_count", q0.size(), 16);
    check_outs("ones", q0, 0, ex, 16);
    tick;

    // 4x4 impulse at index 0 -> all outputs equal the impulse
    clear_q();
    for (int i = 0; i < 16; i++) begin
      vin[i] = (i == 0) ? 5 : 0;
      ex[i]  = 5;
    end
    send_block(1'b1, 16, vin, 1'b0, f1, e1);
    wait_outs(16);
    check_outs("imp", q0, 0, ex, 16);
    tick;

    // 4x4 all most-negative inputs -> DC = 16 * -32768, no wrap
    clear_q();
    for (int i = 0; i < 16; i++) begin
      vin[i] = -32768;
      ex[i]  = (i == 0) ? -524288 : 0;
    end
    send_block(1'b1, 16, vin, 1'b0, f1, e1);
    wait_outs(16);
    check_outs("min", q0, 0, ex, 16);
    check_outs("ming", q1, 0, ex, 16);
    tick;

    // Backpressure with READYO pattern 1,0,0,1,1,0,1 starting at the first
    // emission decision cycle.
    do_reset();
    ro = 1'b0;
    bp_pat   = '{1, 0, 0, 1, 1, 0, 1};
    exp0_cyc = '{0, 3, 4, 6};
    exp1_cyc = '{0, 1, 2, 3};
    send_block(1'b0, 4, v22, 1'b0, f1, e1);
    tick;
    tick;
    for (int i = 0; i < 7; i++) begin
      ro = bp_pat[i][0];
      tick;
    end
    ro = 1'b1;
    tick;
    tick;
    check("bp0_count", q0.size(), 4);
    check("bp1_count", q1.size(), 4);
    check_outs("bp0", q0, 0, e22, 4);
    check_outs("bp1", q1, 0, e22, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q0.size()) check($sformatf("bp0_cyc%0d", i), q0[i].cyc - e1, 3 + exp0_cyc[i]);
      if (i < q1.size()) check($sformatf("bp1_cyc%0d", i), q1[i].cyc - e1, 3 + exp1_cyc[i]);
    end

    // Mode switch: 2x2 immediately followed by 4x4, wrong MODE on
    // non-first samples, garbage driven while not ready.
    // X[r][c] = 4r+c -> row0 120,-16,0,-8; row1 -64,0,0,0; row3 -32,0,0,0
    do_reset();
    for (int i = 0; i < 16; i++) v44[i] = i;
    e44 = '{120, -16, 0, -8, -64, 0, 0, 0, 0, 0, 0, 0, -32, 0, 0, 0};
    send_block(1'b0, 4, v22, 1'b1, f1, e1);
    check("ms_readyi_row", bus0.READYI, 0);
    tick;
    check("ms_readyi_col", bus0.READYI, 0);
    send_block(1'b1, 16, v44, 1'b1, f2, e2);
    check("ms_throughput", f2 - f1, 10);
    wait_outs(20);
    check("ms_count", q0.size(), 20);
    check_outs("ms22", q0, 0, e22, 4);
    check_outs("ms44", q0, 4, e44, 16);
    tick;

    // Reset mid-load and mid-output, then a clean 2x2 block.
    do_reset();
    send_block(1'b0, 2, v44, 1'b0, f1, e1);
    rst = 1'b1;
    #1;
    check("rr_readyi", bus0.READYI, 0);
    tick;
    rst = 1'b0;
    tick;
    send_block(1'b0, 4, v22, 1'b0, f1, e1);
    begin
      int g = 0;
      while (q0.size() < 2 && g < 100) begin
        tick;
        g++;
      end
      check("rr_partial_out", q0.size(), 2);
    end
    check("rr_valid_before", bus0.VALID, 1);
    rst = 1'b1;
    #1;
    check("rr_valid_async", bus0.VALID, 0);
    check("rr_yyout_async", bus0.YYOUT, 0);
    tick;
    rst = 1'b0;
    clear_q();
    for (int i = 0; i < 6; i++) tick;
    check("rr_no_leftover", q0.size(), 0);
    v22 = '{4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    e22 = '{10, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_block(1'b0, 4, v22, 1'b0, f1, e1);
    wait_outs(4);
    tick;
    check("rr_count", q0.size(), 4);
    check_outs("rr", q0, 0, e22, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/h264dc_hadamard.md
# h264dc_hadamard

Parametrised DC-coefficient Hadamard transform for the H.264 encoder. It handles both the 2x2 chroma DC block and the 4x4 Intra16x16 luma DC block, selected per block. The block accepts DC coefficients serially, buffers a whole block, runs a two-pass (row then column) Hadamard, and emits full-precision results serially in raster order. It sits between the forward core transform and the DC quantiser, and replaces the fixed 2x2 chroma-only DC transform.

## Interface
Parameters:
- IN_WIDTH, 16, signed input coefficient width.
- OUT_WIDTH, 20, signed output width. Must be at least IN_WIDTH+4. Results are sign-extended to this width.
- TOGETHER, 0. When 1, a block's output is emitted as one contiguous burst once started.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- READYI  out  1  block can accept a sample this cycle.
- ENABLE  in  1  XXIN and MODE valid this cycle.
- MODE  in  1  0 = 2x2 chroma DC, 1 = 4x4 luma DC; sampled with the first sample of a block.
- XXIN  in  IN_WIDTH  input coefficient, raster order (index = row*N + col).
- VALID  out  1  YYOUT/YYIDX/LAST valid this cycle.
- YYOUT  out  OUT_WIDTH  transformed coefficient.
- YYIDX  out  4  raster index of the YYOUT coefficient.
- LAST  out  1  final coefficient of the block.
- READYO  in  1  downstream permits emission of the next coefficient.

## Operation
- N = 2 (MODE=0) or 4 (MODE=1). Block size is N*N samples.
- Transform: Y = H·X·Hᵀ.
  - H2 = [[1,1],[1,-1]].
  - H4 = [[1,1,1,1],[1,1,-1,-1],[1,-1,-1,1],[1,-1,1,-1]].
- No scaling or rounding is applied; the quantiser applies the luma >>1.
- Arithmetic is two's complement at OUT_WIDTH. The row pass needs IN_WIDTH+2 bits and the column pass IN_WIDTH+4 bits, so overflow is impossible.
- State machine:
  - LOAD: READYI=1. Each cycle with ENABLE=1 writes XXIN to buffer[cnt] and increments cnt. MODE is latched when cnt=0. After sample N*N-1 is accepted, go to ROW.
  - ROW: one cycle. Row Hadamard into an intermediate register bank. Go to COL.
  - COL: one cycle. Column Hadamard into the output bank. Go to OUT.
  - OUT: emits coefficient k, for k = 0..N*N-1, whenever the emit condition holds. The emit condition is READYO=1, or (TOGETHER=1 and k≠0). After emitting k=N*N-1, return to LOAD with cnt=0.
- READYI = 1 only in LOAD and while RESET=0. It is combinational from state.
- ENABLE while READYI=0 is ignored, and the sample is dropped.
- MODE on non-first samples is ignored. MODE cannot change mid-block.

## Timing
- Reset values: READYI=0 while RESET=1. VALID=0, YYOUT=0, YYIDX=0, LAST=0. State=LOAD, cnt=0.
- READYI is 1 in the first cycle after RESET falls.
- Last sample is accepted at edge E:
  - ROW at E+1.
  - COL at E+2.
  - The earliest emission decision is in the cycle after E+2.
  - With READYO=1, VALID is first high after edge E+3.
- Emission is registered. If the emit condition holds in cycle t, then YYOUT/YYIDX/VALID are updated at the end of t, and VALID=1 for exactly one cycle per coefficient.
- VALID never holds a stale value. If the condition is false, VALID=0 next cycle and k does not advance.
- TOGETHER=1: after coefficient 0 is emitted, the remaining N*N-1 coefficients follow on consecutive cycles regardless of READYO.
- LAST=1 coincides with VALID for k=N*N-1.
- READYI rises in the cycle after the final emission decision. The next block's first sample can be accepted then, overlapping the final VALID.
- Throughput with READYO=1 and back-to-back inputs:
  - 2x2: 4 in + 2 + 4 out = 10 cycles per block.
  - 4x4: 16 + 2 + 16 = 34 cycles per block.
- RESET asserted at any point aborts the block: buffer contents discarded, outputs go to reset values immediately, no partial output after release.

## Test plan
- 2x2, XXIN = 1,2,3,4, READYO=1 -> YYOUT = 10, -2, -4, 0; YYIDX 0..3; LAST on the 4th; first VALID 3 cycles after the 4th input edge.
- 4x4, all sixteen inputs = 1 -> YYOUT = 16, then fifteen 0s; LAST on YYIDX=15.
- 4x4, XXIN[0]=5, others 0 -> all sixteen outputs = 5. Then 4x4 all inputs = -32768 (IN_WIDTH=16) -> Y0 = -524288, others 0, no wrap.
- Backpressure, 2x2 1,2,3,4, READYO toggling 1,0,0,1,1,0,1:
  - TOGETHER=0: exactly one VALID per READYO=1 cycle, values unchanged.
  - TOGETHER=1: after the first, three consecutive VALIDs.
- Mode switch: a 2x2 block followed immediately by a 4x4 block, with MODE driven to the wrong value on non-first samples -> both results correct; READYI=0 throughout ROW/COL/OUT; ENABLE during READYI=0 is dropped.
- Reset mid-operation: RESET pulse after 2 of 4 samples and again mid-OUT -> VALID=0 immediately. A fresh 2x2 block 4,3,2,1 then yields 10, 2, 4, 0.
